// File: rtl/mod_writer_pkg.sv
// Shared types and sizing for the modulation sample buffer writer.
package mod_writer_pkg;

  localparam int BUS_AW     = 14;
  localparam int BUS_DW     = 16;
  localparam int PAGE_W     = 1;
  localparam int MOD_AW     = 16;  // equals BUS_AW + 1 + PAGE_W
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [PAGE_W-1:0] page;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] data;
  } mod_word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } wr_state_t;

  // Byte address of the even (odd=0) or odd (odd=1) sample of a queued word.
  function automatic logic [MOD_AW-1:0] byte_addr(input mod_word_t w, input logic odd);
    return {w.page, w.addr, odd};
  endfunction

endpackage

// File: rtl/mod_word_fifo.sv
// Small synchronous FIFO of host words; head entry is presented combinationally.
module mod_word_fifo
  import mod_writer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           push,
  input  mod_word_t                      wdata,
  input  logic                           pop,
  output mod_word_t                      rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  mod_word_t         mem_q [DEPTH];
  mod_word_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO refuses pushes even when the same cycle pops.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset flushes all entries.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/modulation_bus_writer.sv
// Host word writer: queues 16-bit words and serialises them into byte writes
// on the modulation buffer, tracking the highest byte address written.
//
// state  | meaning
// S_IDLE | nothing to emit; leave when the FIFO holds a word
// S_LO   | emit even sample of the head word at {page, addr, 0}
// S_HI   | emit odd sample at {page, addr, 1} and pop the head word
module modulation_bus_writer
  import mod_writer_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              BUS_EN,
  input  logic              BUS_WE,
  input  logic [BUS_AW-1:0] BUS_ADDR,
  input  logic [BUS_DW-1:0] BUS_DATA,
  input  logic [PAGE_W-1:0] PAGE_SEL,
  output logic              BUS_READY,
  input  logic              CLEAR,
  output logic              MOD_WE,
  output logic [MOD_AW-1:0] MOD_WADDR,
  output logic [7:0]        MOD_WDATA,
  output logic [MOD_AW-1:0] MAX_ADDR,
  output logic              IDLE
);

  wr_state_t          state_q, state_d;
  logic               mod_we_q, mod_we_d;
  logic [MOD_AW-1:0]  mod_waddr_q, mod_waddr_d;
  logic [7:0]         mod_wdata_q, mod_wdata_d;
  logic [MOD_AW-1:0]  max_addr_q, max_addr_d;

  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  mod_word_t          push_word, head_word;

  // Ready depends only on registered occupancy, never on the bus inputs.
  assign BUS_READY = ~fifo_full;
  assign push      = BUS_EN & BUS_WE & BUS_READY;
  assign push_word = '{page: PAGE_SEL, addr: BUS_ADDR, data: BUS_DATA};

  mod_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serialiser next-state and registered byte-write outputs.
  always_comb begin
    state_d     = state_q;
    mod_we_d    = 1'b0;
    mod_waddr_d = mod_waddr_q;
    mod_wdata_d = mod_wdata_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_LO;
      end
      S_LO: begin
        mod_we_d    = 1'b1;
        mod_waddr_d = byte_addr(head_word, 1'b0);
        mod_wdata_d = head_word.data[7:0];
        state_d     = S_HI;
      end
      S_HI: begin
        mod_we_d    = 1'b1;
        mod_waddr_d = byte_addr(head_word, 1'b1);
        mod_wdata_d = head_word.data[15:8];
        pop         = 1'b1;
        // Another word is waiting if one stays behind the popped head or is
        // being pushed right now; going straight to S_LO avoids a WE gap.
        if ((fifo_count > FIFO_CW'(1)) || push) state_d = S_LO;
        else                                   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // High-water mark of emitted byte addresses; CLEAR beats a same-cycle update.
  always_comb begin
    max_addr_d = max_addr_q;
    if (CLEAR)                                      max_addr_d = '0;
    else if (mod_we_q && (mod_waddr_q > max_addr_q)) max_addr_d = mod_waddr_q;
  end

  // Serialiser and tracking registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      mod_we_q    <= 1'b0;
      mod_waddr_q <= '0;
      mod_wdata_q <= '0;
      max_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mod_we_q    <= mod_we_d;
      mod_waddr_q <= mod_waddr_d;
      mod_wdata_q <= mod_wdata_d;
      max_addr_q  <= max_addr_d;
    end
  end

  assign MOD_WE    = mod_we_q;
  assign MOD_WADDR = mod_waddr_q;
  assign MOD_WDATA = mod_wdata_q;
  assign MAX_ADDR  = max_addr_q;
  assign IDLE      = (state_q == S_IDLE) & fifo_empty & ~mod_we_q;

endmodule

// File: tb/tb_modulation_bus_writer.sv
// Scoreboard bench for modulation_bus_writer.
module tb_modulation_bus_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BUS_EN = 1'b0;
  logic        BUS_WE = 1'b0;
  logic [13:0] BUS_ADDR = '0;
  logic [15:0] BUS_DATA = '0;
  logic [0:0]  PAGE_SEL = '0;
  logic        BUS_READY;
  logic        CLEAR = 1'b0;
  logic        MOD_WE;
  logic [15:0] MOD_WADDR;
  logic [7:0]  MOD_WDATA;
  logic [15:0] MAX_ADDR;
  logic        IDLE;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   first_we = -1;
  int   last_we = -1;
  int   last_acc = 0;
  int   we_base;
  int   acc_e;

  modulation_bus_writer dut (
    .CLK       (CLK),
    .RST       (RST),
    .BUS_EN    (BUS_EN),
    .BUS_WE    (BUS_WE),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_DATA  (BUS_DATA),
    .PAGE_SEL  (PAGE_SEL),
    .BUS_READY (BUS_READY),
    .CLEAR     (CLEAR),
    .MOD_WE    (MOD_WE),
    .MOD_WADDR (MOD_WADDR),
    .MOD_WDATA (MOD_WDATA),
    .MAX_ADDR  (MAX_ADDR),
    .IDLE      (IDLE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Byte-write monitor: every MOD_WE must match the next expected byte.
  always @(negedge CLK) begin
    if (!RST && MOD_WE === 1'b1) begin
      exp_t e;
      we_cnt++;
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
      chk_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_eq("mod_waddr", 32'(MOD_WADDR), 32'(e.addr));
        chk_eq("mod_wdata", 32'(MOD_WDATA), 32'(e.data));
      end
    end
  end

  // Entered and left at a negedge; waits (bounded) for READY, then writes.
  task automatic write_word(input logic pg, input logic [13:0] a, input logic [15:0] d);
    int   n;
    exp_t e;
    n = 0;
    while (BUS_READY !== 1'b1 && n < 50) begin
      BUS_EN = 1'b0;
      BUS_WE = 1'b0;
      @(negedge CLK);
      n++;
    end
    if (BUS_READY !== 1'b1) begin
      chk_eq("ready_wait", 32'(BUS_READY), 1);
    end else begin
      BUS_EN   = 1'b1;
      BUS_WE   = 1'b1;
      PAGE_SEL = pg;
      BUS_ADDR = a;
      BUS_DATA = d;
      @(negedge CLK);
      last_acc = cyc;
      e.addr = {pg, a, 1'b0};
      e.data = d[7:0];
      exp_q.push_back(e);
      e.addr = {pg, a, 1'b1};
      e.data = d[15:8];
      exp_q.push_back(e);
      BUS_EN = 1'b0;
      BUS_WE = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(IDLE === 1'b1 && exp_q.size() == 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk_eq("idle_reached", 32'(IDLE === 1'b1 && exp_q.size() == 0), 1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge CLK);
  endtask

  initial begin
    idle_cycles(3);
    RST = 1'b0;
    // Reset state
    chk_eq("rst_we", 32'(MOD_WE), 0);
    chk_eq("rst_waddr", 32'(MOD_WADDR), 0);
    chk_eq("rst_wdata", 32'(MOD_WDATA), 0);
    chk_eq("rst_max", 32'(MAX_ADDR), 0);
    chk_eq("rst_idle", 32'(IDLE), 1);
    chk_eq("rst_ready", 32'(BUS_READY), 1);
    idle_cycles(1);

    // Single write, latency t+2 / t+3
    we_base = we_cnt; first_we = -1; last_we = -1;
    write_word(1'b0, 14'h0005, 16'hBEEF);
    wait_idle();
    chk_eq("single_lo_lat", 32'(first_we), 32'(last_acc + 2));
    chk_eq("single_hi_lat", 32'(last_we), 32'(last_acc + 3));
    chk_eq("single_cnt", 32'(we_cnt - we_base), 2);
    chk_eq("single_max", 32'(MAX_ADDR), 32'h000B);

    // Burst of 4 words; READY falls once two are queued; 8 gapless bytes
    idle_cycles(1);
    we_base = we_cnt; first_we = -1; last_we = -1;
    write_word(1'b0, 14'h0100, 16'h1100);
    write_word(1'b0, 14'h0101, 16'h3322);
    chk_eq("burst_ready_full", 32'(BUS_READY), 0);
    write_word(1'b0, 14'h0102, 16'h5544);
    write_word(1'b0, 14'h0103, 16'h7766);
    wait_idle();
    chk_eq("burst_cnt", 32'(we_cnt - we_base), 8);
    chk_eq("burst_span", 32'(last_we - first_we), 7);
    chk_eq("burst_max", 32'(MAX_ADDR), 32'h0207);

    // Top of the address space
    write_word(1'b1, 14'h3FFF, 16'h1234);
    wait_idle();
    chk_eq("top_max", 32'(MAX_ADDR), 32'hFFFF);

    // CLEAR alone, then max tracking with a lower address
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    chk_eq("clear_max", 32'(MAX_ADDR), 0);
    write_word(1'b0, 14'h0010, 16'hA1A0);
    wait_idle();
    chk_eq("max_hi", 32'(MAX_ADDR), 32'h0021);
    write_word(1'b0, 14'h0002, 16'hB1B0);
    wait_idle();
    chk_eq("max_hold", 32'(MAX_ADDR), 32'h0021);

    // CLEAR concurrent with the low-byte MOD_WE
    write_word(1'b0, 14'h0003, 16'hA55A);
    acc_e = last_acc;
    idle_cycles(2);
    chk_eq("clr_we_cycle", 32'(cyc), 32'(acc_e + 2));
    chk_eq("clr_we_active", 32'(MOD_WE), 1);
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    chk_eq("clr_wins", 32'(MAX_ADDR), 0);
    wait_idle();
    chk_eq("clr_after", 32'(MAX_ADDR), 32'h0007);

    // Write held while full, across the cycle that pops
    we_base = we_cnt;
    write_word(1'b0, 14'h0020, 16'hC1C0);
    write_word(1'b0, 14'h0021, 16'hC3C2);
    chk_eq("full_ready", 32'(BUS_READY), 0);
    BUS_EN = 1'b1; BUS_WE = 1'b1; BUS_ADDR = 14'h0030; BUS_DATA = 16'hDEAD;
    idle_cycles(2);
    chk_eq("full_ready_after_pop", 32'(BUS_READY), 1);
    BUS_EN = 1'b0; BUS_WE = 1'b0;
    wait_idle();
    chk_eq("full_drop_cnt", 32'(we_cnt - we_base), 4);
    chk_eq("full_max", 32'(MAX_ADDR), 32'h0043);

    // Read strobe (EN without WE) does nothing
    we_base = we_cnt;
    BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 14'h0050; BUS_DATA = 16'hFACE;
    idle_cycles(4);
    BUS_EN = 1'b0;
    idle_cycles(5);
    chk_eq("rd_no_we", 32'(we_cnt - we_base), 0);
    chk_eq("rd_idle", 32'(IDLE), 1);

    // Reset during S_LO with two words queued
    write_word(1'b0, 14'h0060, 16'h0102);
    write_word(1'b0, 14'h0061, 16'h0304);
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    chk_eq("mrst_we", 32'(MOD_WE), 0);
    chk_eq("mrst_ready", 32'(BUS_READY), 1);
    chk_eq("mrst_idle", 32'(IDLE), 1);
    chk_eq("mrst_max", 32'(MAX_ADDR), 0);
    chk_eq("mrst_waddr", 32'(MOD_WADDR), 0);
    RST = 1'b0;
    we_base = we_cnt;
    idle_cycles(12);
    chk_eq("mrst_no_we", 32'(we_cnt - we_base), 0);
    chk_eq("mrst_idle_after", 32'(IDLE), 1);

    chk_eq("sb_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/modulation_bus_writer.md
Name: modulation_bus_writer

Overview:
- Host-side writer for the modulation sample buffer; the buffer's consumer reads bytes via a 16-bit ADDR and 8-bit MOD.
- Accepts 16-bit host bus write words, each holding two 8-bit modulation samples.
- Queues accepted words in a 2-entry FIFO and serialises each word into two byte writes on the buffer's write port.
- Tracks the highest byte address written so firmware can derive MOD_CYCLE.

Parameters:
- BUS_AW, 14, host word-address width within one page.
- BUS_DW, 16, host data width (two samples per word, fixed).
- MOD_AW, 16, buffer byte-address width; must equal BUS_AW+1+PAGE_W.
- PAGE_W, 1, page-select width.
- FIFO_DEPTH, 2, word FIFO depth (power of two).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- BUS_EN  in  1  host access strobe
- BUS_WE  in  1  host write enable; a write requires BUS_EN=1 and BUS_WE=1
- BUS_ADDR  in  BUS_AW  word address within the page
- BUS_DATA  in  BUS_DW  [7:0]=even sample, [15:8]=odd sample
- PAGE_SEL  in  PAGE_W  page number, sampled when a word is accepted
- BUS_READY  out  1  word can be accepted this cycle
- CLEAR  in  1  single-cycle pulse that clears MAX_ADDR
- MOD_WE  out  1  buffer byte-write enable
- MOD_WADDR  out  MOD_AW  buffer byte address
- MOD_WDATA  out  8  buffer byte data
- MAX_ADDR  out  MOD_AW  highest byte address written since reset or CLEAR
- IDLE  out  1  FIFO empty and serialiser idle

Behaviour:
- Reset values: MOD_WE=0, MOD_WADDR=0, MOD_WDATA=0, MAX_ADDR=0, IDLE=1, FIFO empty, FSM=S_IDLE.
- RST has priority over all other inputs. Reset mid-operation flushes the FIFO and drops in-flight bytes; MOD_WE=0 from the next cycle.
- BUS_READY = (fifo_count < FIFO_DEPTH). It is combinational from registered state only and never depends on BUS_* inputs.
- Accept = BUS_EN & BUS_WE & BUS_READY. The pushed entry is {PAGE_SEL, BUS_ADDR, BUS_DATA}.
- If BUS_EN & BUS_WE arrive while BUS_READY=0, the write is dropped. The host polls BUS_READY.
- Push and pop in the same cycle are allowed; the count is unchanged.
- No push is accepted while full, even if a pop occurs that cycle.
- FSM states:
  - S_IDLE: if FIFO non-empty, go to S_LO.
  - S_LO: register MOD_WE=1, MOD_WADDR={page, addr, 1'b0}, MOD_WDATA=data[7:0]; go to S_HI.
  - S_HI: register MOD_WE=1, MOD_WADDR={page, addr, 1'b1}, MOD_WDATA=data[15:8]; pop the entry. Go to S_LO if an entry remains after the pop (including one pushed this cycle), else S_IDLE.
- All MOD_* outputs are registered. MOD_WE=0 in any cycle the FSM is not emitting a byte.
- Latency: for a word accepted into an empty idle block at cycle t:
  - low byte has MOD_WE=1 at t+2;
  - high byte has MOD_WE=1 at t+3.
- Sustained throughput is one word per 2 cycles. Back-to-back words produce no MOD_WE gap.
- MAX_ADDR:
  - On each MOD_WE cycle, if MOD_WADDR > MAX_ADDR, load MOD_WADDR (unsigned compare).
  - CLEAR wins over a concurrent update: MAX_ADDR=0 next cycle and that byte is not tracked.
  - Not reset by wrap; address 0xFFFF saturates naturally.
- Address wrap: there is no wrap inside the block; page plus word address covers the full MOD_AW space.
- IDLE = (FSM==S_IDLE) & FIFO empty & ~MOD_WE.

Decomposition:
- Package mod_writer_pkg:
  - constants BUS_AW, BUS_DW, MOD_AW, PAGE_W;
  - typedef struct packed mod_word_t {page, addr, data};
  - typedef enum logic [1:0] wr_state_t {S_IDLE, S_LO, S_HI}.
- One sub-module, mod_word_fifo: a synchronous FIFO of mod_word_t with push, pop, full, empty and count. The serialiser and MAX_ADDR tracking stay in the top.

Test Plan:
- Single write, PAGE_SEL=0, BUS_ADDR=0x0005, BUS_DATA=0xBEEF → MOD_WE at t+2 with addr 0x000A / data 0xEF, at t+3 with addr 0x000B / data 0xBE; MAX_ADDR=0x000B; IDLE returns to 1.
- Burst of 4 words on consecutive cycles → BUS_READY deasserts once 2 are queued. Words the bench holds until READY all arrive, giving 8 contiguous MOD_WE cycles with no gap and correct ordering.
- PAGE_SEL=1, BUS_ADDR=0x3FFF, BUS_DATA=0x1234 → bytes at 0xFFFE=0x34 and 0xFFFF=0x12; MAX_ADDR=0xFFFF.
- Write to addr 0x0010 then addr 0x0002 → MAX_ADDR stays 0x0021. CLEAR pulsed in the same cycle as a MOD_WE → MAX_ADDR=0 next cycle.
- RST asserted during S_LO with 2 words queued → next cycle MOD_WE=0, FIFO empty, BUS_READY=1, IDLE=1, MAX_ADDR=0, and no further writes.
- BUS_EN=1, BUS_WE=0 or write while full → no FIFO change and no MOD_WE activity attributable to it.
